fpm_ctrl_fsm: RTL
=================

# fpm_ctrl_fsm

Sequencing controller for the 32-bit floating-point multiplier. It sits directly upstream of the control-signal decoder and owns the 3-bit state register `Q`. The decoder turns `Q` into the datapath strobes: reset, operand register enables, multiply enable and result write enables. The block takes a start/abort handshake from the host, holds the multiply state for a parameterised number of cycles, then reports completion and counts finished operations.

## Interface
- `MUL_CYCLES`, default 3: cycles spent in state MUL (010); legal range 1..15.
- `OPCNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  request a new multiply; sampled only in IDLE or DONE.
- `abort`  in  1  cancel the operation in progress; priority over `start`.
- `Q`  out  3  state register, fed straight to the output decoder.
- `busy`  out  1  high in LOAD, MUL, WRITE, DONE.
- `done`  out  1  high for exactly the one cycle `Q`=100.
- `result_valid`  out  1  sticky; product register holds a completed result.
- `op_count`  out  `OPCNT_W`  completed operations, wraps.

## Operation
- State encoding, fixed to match the decoder:
  - IDLE=000: decoder drives datapath reset.
  - LOAD=001: operand register enables.
  - MUL=010: mul_enable, rwe_a.
  - WRITE=011: rwe_b.
  - DONE=100: decoder drives nothing.
- `Q` is a registered output, with no combinational path from inputs to `Q`. `busy` and `done` decode from `Q`.
- Transitions are evaluated in this priority order:
  1. `reset_n`=0 → IDLE.
  2. `abort`=1 while not IDLE → IDLE.
  3. Normal flow:
     - IDLE: `start`=1 → LOAD, else stay.
     - LOAD → MUL unconditionally; load down-counter `cnt` with `MUL_CYCLES`-1.
     - MUL: `cnt`≠0 → stay, `cnt` decrements; `cnt`=0 → WRITE.
     - WRITE → DONE.
     - DONE: `start`=1 → LOAD (back-to-back), else → IDLE.
     - Codes 101, 110, 111 → IDLE on the next edge. No other side effect.
- `abort` in IDLE is ignored. `abort` and `start` together in DONE → IDLE.
- `cnt` is 4 bits wide. It holds its value outside MUL and never underflows.
- `op_count` increments by 1 on the edge entering DONE. All-ones wraps to 0. Abort does not increment it.
- `result_valid`:
  - Set on the edge entering DONE.
  - Cleared on the edge where `start` is accepted (IDLE or DONE → LOAD).
  - Cleared on the edge where `abort` takes effect.
  - Otherwise holds.

## Timing
- Reset values: `Q`=000, `cnt`=0, `busy`=0, `done`=0, `result_valid`=0, `op_count`=0.
- Reset applied mid-operation returns everything to the reset values on that edge, with no `done` pulse.
- Start accepted at edge t, from IDLE:
  - `Q`=001 during cycle t+1.
  - `Q`=010 during t+2 .. t+1+`MUL_CYCLES`.
  - `Q`=011 during t+2+`MUL_CYCLES`.
  - `Q`=100 and `done`=1 during t+3+`MUL_CYCLES`.
- Latency from start to done is `MUL_CYCLES`+3 edges: 6 at the default.
- Back-to-back throughput: one operation per `MUL_CYCLES`+3 cycles, because `start` held in DONE skips IDLE.
- `start` held high continuously runs operations back-to-back, with no idle cycles between them.
- Abort sampled at edge t: `Q`=000 during t+1. The decoder asserts datapath reset in that cycle.
- `result_valid` is 0 from the LOAD cycle until the DONE cycle of the same operation.

## Test plan
- Reset: drive `reset_n`=0 for 2 edges with `start`=1 → `Q`=000, `busy`=0, `op_count`=0, `result_valid`=0. Release the reset → `Q`=001 on the next edge.
- Single op, `MUL_CYCLES`=3: one-cycle `start` pulse at edge 0 → `Q` sequence 001, 010, 010, 010, 011, 100, 000 on edges 1-7. `done`=1 only on edge 6. `op_count`=1. `result_valid`=1 from edge 6 until the next start.
- Back-to-back: `start` held high for two operations → `Q` goes 100 → 001 with no 000 in between. `done` pulses 6 cycles apart. `op_count`=2.
- Abort during MUL: start, then `abort`=1 on the second MUL cycle → `Q`=000 on the next edge. No `done` pulse, `op_count` unchanged, `result_valid`=0.
- Abort and start in DONE together → `Q`=000, then stays idle once `start` drops. A `start` pulse while already in IDLE with `abort`=1 still goes to LOAD, since abort is ignored in IDLE.
- Wrap, with `OPCNT_W`=4 and `MUL_CYCLES`=1: run 16 operations → `op_count` goes 15 → 0. Force `Q`=110 via the bench → `Q`=000 on the next edge.

Source files
------------

// File: rtl/fpm_ctrl_fsm.sv
// Sequencing controller for the 32-bit floating-point multiplier.
// Owns the 3-bit state register Q consumed by the control-signal decoder,
// times the multiply phase with a 4-bit down-counter, flags completed
// results and counts finished operations. MUL_CYCLES must lie in 1..15
// so that MUL_CYCLES-1 fits the 4-bit cycle counter.
module fpm_ctrl_fsm #(
    parameter int MUL_CYCLES = 3,
    parameter int OPCNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic [2:0]         Q,
    output logic               busy,
    output logic               done,
    output logic               result_valid,
    output logic [OPCNT_W-1:0] op_count
);

    // State codes are fixed by the downstream decoder; do not re-encode.
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_MUL   = 3'b010;
    localparam logic [2:0] S_WRITE = 3'b011;
    localparam logic [2:0] S_DONE  = 3'b100;

    // The counter is loaded with MUL_CYCLES-1 so that MUL lasts exactly
    // MUL_CYCLES cycles including the cycle in which it reaches zero.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OPCNT_W-1:0] op_count_q, op_count_d;
    logic               result_valid_q, result_valid_d;

    // Next-state, cycle counter, completion counter and result flag.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_count_d     = op_count_q;
        result_valid_d = result_valid_q;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over everything except reset; the cancelled
            // operation is not counted and leaves no valid result.
            state_d        = S_IDLE;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d        = S_LOAD;
                        result_valid_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    state_d = S_MUL;
                    cnt_d   = CNT_LOAD;
                end
                S_MUL: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Entering DONE: the product register now holds a result.
                    state_d        = S_DONE;
                    op_count_d     = op_count_q + 1'b1;
                    result_valid_d = 1'b1;
                end
                S_DONE: begin
                    // A start held here chains straight into the next load.
                    if (start) begin
                        state_d        = S_LOAD;
                        result_valid_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    // Unused codes recover to IDLE with no other effect.
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            op_count_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_count_q     <= op_count_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        Q            = state_q;
        busy         = (state_q == S_LOAD) || (state_q == S_MUL) ||
                       (state_q == S_WRITE) || (state_q == S_DONE);
        done         = (state_q == S_DONE);
        result_valid = result_valid_q;
        op_count     = op_count_q;
    end

endmodule
